booth4_pp_seq: RTL and testbench

- Parametrised, sequential radix-4 Booth partial-product generator with built-in accumulation.
- Accepts one multiplier/multiplicand pair per transaction and Booth-encodes the multiplier internally.
- Emits one exact partial product per clock, with its sign and index, for downstream reduction-tree testing.
- Returns the full accumulated product through a ready/valid handshake.
- Successor to the fixed 8-bit, 4-row combinational PP wordslice: adds width and signedness parameters and real sequencing.

---
 rtl/booth4_pp_seq.sv | 132 +++++++++++++
 tb/tb_booth4_pp_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth4_pp_seq.sv
// Sequential radix-4 Booth partial-product generator: one exact partial product
// per cycle with sign and index, plus the accumulated product on a ready/valid port.
module booth4_pp_seq #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      x,
    input  logic [WIDTH-1:0]                      y,
    output logic                                  pp_valid,
    output logic [WIDTH+1:0]                      pp,
    output logic                                  pp_sign,
    output logic [$clog2(WIDTH/2 + ((SIGNED != 0) ? 0 : 1))-1:0] pp_idx,
    output logic                                  pp_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [2*WIDTH-1:0]                    product
);

    localparam int NPP  = WIDTH / 2 + ((SIGNED != 0) ? 0 : 1);
    localparam int IW   = $clog2(NPP);
    localparam int XW   = 2 * NPP;
    localparam int YW   = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 2;
    localparam logic [IW-1:0] LAST_ROW = IW'(NPP - 1);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t          state;
    logic [XW:0]     x_sh;      // bit 0 is the implicit xe[-1] = 0
    logic [YW-1:0]   y_ext_q;
    logic [ACCW-1:0] acc;
    logic [IW-1:0]   row;

    logic [XW-1:0]   x_ext;
    logic [YW-1:0]   y_ext;
    logic [YW-1:0]   pp_next;
    logic [ACCW-1:0] pp_wide;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        x_ext = '0;
        y_ext = '0;
        if (SIGNED != 0) begin
            x_ext = XW'($signed(x));
            y_ext = YW'($signed(y));
        end else begin
            x_ext = XW'(x);
            y_ext = YW'(y);
        end
    end

    // Two extra bits let +/-2*y stay exact, including -2 * (-2^(WIDTH-1)).
    always_comb begin
        pp_next = '0;
        unique case (x_sh[2:0])
            3'b001, 3'b010: pp_next = y_ext_q;
            3'b011:         pp_next = y_ext_q << 1;
            3'b100:         pp_next = -(y_ext_q << 1);
            3'b101, 3'b110: pp_next = -y_ext_q;
            default:        pp_next = '0;
        endcase
        pp_wide = ACCW'($signed(pp_next)) << {row, 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            pp_valid  <= 1'b0;
            pp        <= '0;
            pp_sign   <= 1'b0;
            pp_idx    <= '0;
            pp_last   <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            x_sh      <= '0;
            y_ext_q   <= '0;
            acc       <= '0;
            row       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sh     <= {x_ext, 1'b0};
                        y_ext_q  <= y_ext;
                        acc      <= '0;
                        row      <= '0;
                        in_ready <= 1'b0;
                        state    <= GEN;
                    end
                end
                GEN: begin
                    pp_valid <= 1'b1;
                    pp       <= pp_next;
                    pp_sign  <= pp_next[YW-1];
                    pp_idx   <= row;
                    pp_last  <= (row == LAST_ROW);
                    acc      <= acc + pp_wide;
                    x_sh     <= x_sh >> 2;
                    row      <= row + 1'b1;
                    if (row == LAST_ROW) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    pp_valid <= 1'b0;
                    pp       <= '0;
                    pp_sign  <= 1'b0;
                    pp_idx   <= '0;
                    pp_last  <= 1'b0;
                    // First DONE cycle publishes the product; later ones wait for the consumer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        product   <= acc[2*WIDTH-1:0];
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth4_pp_seq.sv
// Directed and randomised check of booth4_pp_seq across 8/16-bit, signed/unsigned builds.
module tb_booth4_pp_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid  [4];
    logic        out_ready [4];
    logic [15:0] x_in      [4];
    logic [15:0] y_in      [4];

    logic [3:0]  ir_all, pv_all, ps_all, pl_all, ov_all;
    logic [63:0] pp_all   [4];
    logic [3:0]  idx_all  [4];
    logic [31:0] prod_all [4];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint xbit(longint v, int j);
        return (j < 0) ? 64'sd0 : ((v >>> j) & 64'sd1);
    endfunction

    function automatic longint digit(longint v, int r);
        return -2 * xbit(v, 2 * r + 1) + xbit(v, 2 * r) + xbit(v, 2 * r - 1);
    endfunction

    // Instances: 0 = 8-bit signed, 1 = 8-bit unsigned, 2 = 16-bit signed, 3 = 16-bit unsigned.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W   = (g < 2) ? 8 : 16;
        localparam int S   = (g % 2 == 0) ? 1 : 0;
        localparam int N   = W / 2 + ((S != 0) ? 0 : 1);
        localparam int IWL = $clog2(N);

        logic [W+1:0]   pp;
        logic [IWL-1:0] idx;
        logic [2*W-1:0] prod;
        logic           ir, pv, ps, pl, ov;

        booth4_pp_seq #(.WIDTH(W), .SIGNED(S)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid[g]),
            .in_ready (ir),
            .x        (x_in[g][W-1:0]),
            .y        (y_in[g][W-1:0]),
            .pp_valid (pv),
            .pp       (pp),
            .pp_sign  (ps),
            .pp_idx   (idx),
            .pp_last  (pl),
            .out_valid(ov),
            .out_ready(out_ready[g]),
            .product  (prod)
        );

        assign ir_all[g]   = ir;
        assign pv_all[g]   = pv;
        assign ps_all[g]   = ps;
        assign pl_all[g]   = pl;
        assign ov_all[g]   = ov;
        assign pp_all[g]   = 64'($signed(pp));
        assign idx_all[g]  = 4'(idx);
        assign prod_all[g] = 32'(prod);

        longint mx, my;
        int     rows;
        bit     armed, got;
        int     hs;
        longint mask = longint'((64'd1 << (2 * W)) - 64'd1);

        always @(posedge clk) begin
            if (reset) begin
                armed <= 1'b0;
            end else if (in_valid[g] && ir) begin
                if (S != 0) begin
                    mx <= longint'($signed(x_in[g][W-1:0]));
                    my <= longint'($signed(y_in[g][W-1:0]));
                end else begin
                    mx <= longint'(x_in[g][W-1:0]);
                    my <= longint'(y_in[g][W-1:0]);
                end
                rows  <= 0;
                got   <= 1'b0;
                armed <= 1'b1;
            end else begin
                if (pv) rows <= rows + 1;
                if (ov) got <= 1'b1;
            end
            if (!reset && ov && out_ready[g]) hs <= hs + 1;
        end

        always @(negedge clk) begin
            if (pv) begin
                check("mon_armed", 64'(armed), 64'd1);
                check("mon_idx",   64'(idx), 64'(rows));
                check("mon_pp",    pp_all[g], digit(mx, rows) * my);
                check("mon_sign",  64'(ps), 64'((digit(mx, rows) * my) < 0));
                check("mon_last",  64'(pl), 64'(rows == N - 1));
            end else begin
                check("mon_idle", {60'd0, pp != '0, ps, idx != '0, pl}, 64'd0);
            end
            if (ov) begin
                if (!got) check("mon_rows", 64'(rows), 64'(N));
                check("mon_product", 64'(prod), (mx * my) & mask);
            end
        end
    end

    function automatic int hs_sum();
        return g_dut[0].hs + g_dut[1].hs + g_dut[2].hs + g_dut[3].hs;
    endfunction

    task automatic send(input int g, input int xv, input int yv);
        check("send_ready", 64'(ir_all[g]), 64'd1);
        x_in[g]     = 16'(xv);
        y_in[g]     = 16'(yv);
        in_valid[g] = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
        x_in[g]     = 16'hA5A5;
        y_in[g]     = 16'h5A5A;
        check("send_busy", 64'(ir_all[g]), 64'd0);
        check("send_no_pp", 64'(pv_all[g]), 64'd0);
    endtask

    task automatic expect_row(input int g, input int idx, input longint val, input bit last);
        @(negedge clk);
        check("row_valid", 64'(pv_all[g]), 64'd1);
        check("row_idx",   64'(idx_all[g]), 64'(idx));
        check("row_pp",    pp_all[g], val);
        check("row_sign",  64'(ps_all[g]), 64'(val < 0));
        check("row_last",  64'(pl_all[g]), 64'(last));
    endtask

    task automatic wait_out(input int g, input int budget);
        int n = 0;
        while (!ov_all[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("out_timeout", 64'(ov_all[g]), 64'd1);
    endtask

    task automatic release_out(input int g);
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
        check("rel_out_valid", 64'(ov_all[g]), 64'd0);
        check("rel_in_ready",  64'(ir_all[g]), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 4; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            x_in[g]      = '0;
            y_in[g]      = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_in_ready",  64'(ir_all[0]), 64'd1);
        check("rst_pp_valid",  64'(pv_all[0]), 64'd0);
        check("rst_out_valid", 64'(ov_all[0]), 64'd0);
        check("rst_product",   64'(prod_all[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 3 * 5, signed 8-bit
        send(0, 3, 5);
        expect_row(0, 0, -5, 1'b0);
        expect_row(0, 1,  5, 1'b0);
        expect_row(0, 2,  0, 1'b0);
        expect_row(0, 3,  0, 1'b1);
        check("t1_no_early_out", 64'(ov_all[0]), 64'd0);
        @(negedge clk);
        check("t1_out_valid", 64'(ov_all[0]), 64'd1);
        check("t1_product",   64'(prod_all[0]), 64'h000F);
        release_out(0);

        // -128 * -128, signed 8-bit: row 3 needs the full +256
        send(0, -128, -128);
        expect_row(0, 0, 0, 1'b0);
        expect_row(0, 1, 0, 1'b0);
        expect_row(0, 2, 0, 1'b0);
        expect_row(0, 3, 256, 1'b1);
        @(negedge clk);
        check("t2_product", 64'(prod_all[0]), 64'h4000);
        release_out(0);

        // 255 * 255, unsigned 8-bit: five rows
        send(1, 255, 255);
        expect_row(1, 0, -255, 1'b0);
        expect_row(1, 1, 0, 1'b0);
        expect_row(1, 2, 0, 1'b0);
        expect_row(1, 3, 0, 1'b0);
        expect_row(1, 4, 255, 1'b1);
        check("t3_no_early_out", 64'(ov_all[1]), 64'd0);
        @(negedge clk);
        check("t3_out_valid", 64'(ov_all[1]), 64'd1);
        check("t3_product",   64'(prod_all[1]), 64'hFE01);
        release_out(1);

        // Backpressure: -7 * 9 held for three cycles, extra in_valid ignored
        send(0, -7, 9);
        repeat (4) @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("bp_out_valid", 64'(ov_all[0]), 64'd1);
            check("bp_product",   64'(prod_all[0]), 64'hFFC1);
            check("bp_in_ready",  64'(ir_all[0]), 64'd0);
            in_valid[0] = 1'b1;
            x_in[0]     = 16'd55;
            y_in[0]     = 16'd66;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        release_out(0);
        @(negedge clk);
        check("bp_no_ghost", 64'(pv_all[0]), 64'd0);
        check("bp_held",     64'(prod_all[0]), 64'hFFC1);

        // Reset after row 1, then a clean transaction
        send(0, 100, 77);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("ar_in_ready",  64'(ir_all[0]), 64'd1);
        check("ar_pp_valid",  64'(pv_all[0]), 64'd0);
        check("ar_pp",        pp_all[0], 64'd0);
        check("ar_pp_sign",   64'(ps_all[0]), 64'd0);
        check("ar_pp_idx",    64'(idx_all[0]), 64'd0);
        check("ar_pp_last",   64'(pl_all[0]), 64'd0);
        check("ar_out_valid", 64'(ov_all[0]), 64'd0);
        check("ar_product",   64'(prod_all[0]), 64'd0);
        @(negedge clk);
        check("ar_quiet", 64'(pv_all[0]), 64'd0);
        send(0, 2, -3);
        wait_out(0, 20);
        check("ar_new_product", 64'(prod_all[0]), 64'hFFFA);
        release_out(0);

        // Random sweep: all four builds in parallel, random consumer stalls
        for (int r = 0; r < 500; r++) begin
            int target;
            int cycles;
            for (int g = 0; g < 4; g++) begin
                x_in[g]     = 16'($urandom);
                y_in[g]     = 16'($urandom);
                in_valid[g] = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < 4; g++) in_valid[g] = 1'b0;
            target = hs_sum() + 4;
            cycles = 0;
            while (hs_sum() < target && cycles < 200) begin
                for (int g = 0; g < 4; g++) out_ready[g] = 1'($urandom_range(0, 1));
                @(negedge clk);
                cycles++;
            end
            check("sweep_timeout", 64'(hs_sum() >= target), 64'd1);
            for (int g = 0; g < 4; g++) out_ready[g] = 1'b0;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
